// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: memory-mapped register slave with pad synchroniser,
// optional prescaled debounce, per-pin edge capture and a maskable level irq.
// The tri-state buffers themselves live outside this block; gpio_s=1 means hi-Z.
module gpio_bank_ctrl #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter int              DB_DIV_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic             readdatavalid,
    input  logic [WIDTH-1:0] gpio_r,
    output logic [WIDTH-1:0] gpio_w,
    output logic [WIDTH-1:0] gpio_s,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_DIR_S    = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;
    localparam logic [2:0] ADDR_DB_DIV   = 3'd7;

    localparam logic [DB_DIV_W-1:0] DB_ONE = 1;

    logic [WIDTH-1:0]    data_out;
    logic [WIDTH-1:0]    dir_s;
    logic [WIDTH-1:0]    rise_en;
    logic [WIDTH-1:0]    fall_en;
    logic [WIDTH-1:0]    edge_cap;
    logic [WIDTH-1:0]    irq_mask;
    logic [DB_DIV_W-1:0] db_div;
    logic [DB_DIV_W-1:0] db_cnt;

    logic [WIDTH-1:0]    sync1;
    logic [WIDTH-1:0]    sync2;
    logic [WIDTH-1:0]    smp;
    logic [WIDTH-1:0]    deb;
    logic [WIDTH-1:0]    deb_q;

    logic [WIDTH-1:0]    wdata_w;
    logic [WIDTH-1:0]    w1c;
    logic [WIDTH-1:0]    agree;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    fall;
    logic                db_wr;
    logic                tick;
    logic [31:0]         rd_mux;

    assign wdata_w = writedata[WIDTH-1:0];
    assign db_wr   = write && (address == ADDR_DB_DIV);
    assign w1c     = (write && (address == ADDR_EDGE_CAP)) ? wdata_w : '0;

    // Prescaler is a down-counter reloaded from DB_DIV; a zero count is the
    // sampling tick, giving one tick every DB_DIV+1 cycles.
    assign tick    = (db_cnt == '0);

    // A pin follows the previous tick's sample only when the current sample agrees.
    assign agree   = ~(sync2 ^ smp);

    assign rise    = deb & ~deb_q & rise_en;
    assign fall    = ~deb & deb_q & fall_en;

    assign gpio_w  = data_out;
    assign gpio_s  = dir_s;

    // Configuration registers written from the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_OUT;
            dir_s    <= '1;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            db_div   <= '0;
        end else if (write) begin
            case (address)
                ADDR_DATA_OUT: data_out <= wdata_w;
                ADDR_DIR_S:    dir_s    <= wdata_w;
                ADDR_RISE_EN:  rise_en  <= wdata_w;
                ADDR_FALL_EN:  fall_en  <= wdata_w;
                ADDR_IRQ_MASK: irq_mask <= wdata_w;
                ADDR_DB_DIV:   db_div   <= writedata[DB_DIV_W-1:0];
                default: ;
            endcase
        end
    end

    // Debounce prescaler; a DB_DIV write restarts the tick period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
        end else if (db_wr) begin
            db_cnt <= writedata[DB_DIV_W-1:0];
        end else if (tick) begin
            db_cnt <= db_div;
        end else begin
            db_cnt <= db_cnt - DB_ONE;
        end
    end

    // Pad synchroniser, debounce filter and edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            smp   <= '0;
            deb   <= '0;
            deb_q <= '0;
        end else begin
            sync1 <= gpio_r;
            sync2 <= sync1;
            deb_q <= deb;
            if (db_div == '0) begin
                deb <= sync2;
            end else if (tick) begin
                smp <= sync2;
                deb <= (agree & smp) | (~agree & deb);
            end
        end
    end

    // Edge capture with write-1-to-clear; a new edge beats a clear on the same bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~w1c) | rise | fall;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    // Read data selection from current register contents
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA_IN:  rd_mux = 32'(deb);
            ADDR_DATA_OUT: rd_mux = 32'(data_out);
            ADDR_DIR_S:    rd_mux = 32'(dir_s);
            ADDR_RISE_EN:  rd_mux = 32'(rise_en);
            ADDR_FALL_EN:  rd_mux = 32'(fall_en);
            ADDR_EDGE_CAP: rd_mux = 32'(edge_cap);
            ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
            ADDR_DB_DIV:   rd_mux = 32'(db_div);
            default:       rd_mux = '0;
        endcase
    end

    // Registered read response, fixed one-cycle latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule
